prbs_div_checker: RTL and testbench



---
 rtl/prbs_div_checker.sv | 173 +++++++++++++++++
 tb/tb_prbs_div_checker.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_div_checker.sv
// Divided-clock half-period meter plus self-synchronising x^16+x^14+x^13+x^11+1 PRBS error checker; optional err_clr port via ERR_CLEAR_EN.
// All outputs registered, one cycle after the sampled inputs; ena=0 stalls every register (err_pulse drops to 0).
module prbs_div_checker #(
    parameter int CNT_W       = 16,
    parameter int ERR_W       = 8,
    parameter int LOSS_THRESH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
`ifdef ERR_CLEAR_EN
    input  logic             err_clr,
`endif
    input  logic             div_in,
    input  logic             prbs_in,
    output logic [CNT_W-1:0] half_period,
    output logic             period_valid,
    output logic             period_ovf,
    output logic             prbs_lock,
    output logic [ERR_W-1:0] err_count,
    output logic             err_pulse
);

    typedef enum logic {SEED = 1'b0, CHECK = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;
    localparam logic [3:0]       LOSS_LIM = 4'(LOSS_THRESH);

    logic             div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_flag_q, ovf_flag_d;
    logic             seen_edge_q, seen_edge_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic             valid_q, valid_d;
    logic             povf_q, povf_d;
    logic             toggle;

    state_t           state_q, state_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic [15:0]      sr_q, sr_d;
    logic [3:0]       miss_q, miss_d;
    logic             lock_q, lock_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             pulse_q, pulse_d;
    logic             pred;

    assign toggle = div_in ^ div_q;

    always_comb begin
        div_d       = div_q;
        cnt_d       = cnt_q;
        ovf_flag_d  = ovf_flag_q;
        seen_edge_d = seen_edge_q;
        half_d      = half_q;
        valid_d     = valid_q;
        povf_d      = povf_q;
        if (ena) begin
            div_d = div_in;
            if (toggle) begin
                cnt_d       = '0;
                ovf_flag_d  = 1'b0;
                seen_edge_d = 1'b1;
                // The very first edge only starts the clock; its partial interval is meaningless.
                if (seen_edge_q) begin
                    if (ovf_flag_q) begin
                        povf_d  = 1'b1;
                        valid_d = 1'b0;
                    end else begin
                        povf_d  = 1'b0;
                        valid_d = (cnt_q == half_q);
                        half_d  = cnt_q;
                    end
                end
            end else begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                ovf_flag_d = ovf_flag_q | (cnt_d == CNT_MAX);
            end
        end
    end

    assign pred = sr_q[15] ^ sr_q[13] ^ sr_q[12] ^ sr_q[10];

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        miss_d    = miss_q;
        err_d     = err_q;
        pulse_d   = 1'b0;
        if (ena) begin
            if (state_q == SEED) begin
                sr_d      = {sr_q[14:0], prbs_in};
                bit_cnt_d = bit_cnt_q + 5'd1;
                // An all-zero seed would lock the reference LFSR up, so keep seeding.
                if (bit_cnt_d == 5'd16) begin
                    bit_cnt_d = '0;
                    if (sr_d != '0) begin
                        state_d = CHECK;
                        miss_d  = '0;
                    end
                end
            end else begin
                // Free-run on the local reference so a single bad bit costs one error only.
                sr_d = {sr_q[14:0], pred};
                if (prbs_in != pred) begin
                    pulse_d = 1'b1;
                    if (err_q != ERR_MAX) begin
                        err_d = err_q + ERR_W'(1);
                    end
                    miss_d = miss_q + 4'd1;
                    if (miss_d == LOSS_LIM) begin
                        state_d   = SEED;
                        bit_cnt_d = '0;
                        miss_d    = '0;
                    end
                end else begin
                    miss_d = '0;
                end
            end
        end
`ifdef ERR_CLEAR_EN
        if (err_clr) begin
            err_d = '0;
        end
`endif
        lock_d = (state_d == CHECK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q       <= 1'b0;
            cnt_q       <= '0;
            ovf_flag_q  <= 1'b0;
            seen_edge_q <= 1'b0;
            half_q      <= '0;
            valid_q     <= 1'b0;
            povf_q      <= 1'b0;
            state_q     <= SEED;
            bit_cnt_q   <= '0;
            sr_q        <= '0;
            miss_q      <= '0;
            lock_q      <= 1'b0;
            err_q       <= '0;
            pulse_q     <= 1'b0;
        end else begin
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            ovf_flag_q  <= ovf_flag_d;
            seen_edge_q <= seen_edge_d;
            half_q      <= half_d;
            valid_q     <= valid_d;
            povf_q      <= povf_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sr_q        <= sr_d;
            miss_q      <= miss_d;
            lock_q      <= lock_d;
            err_q       <= err_d;
            pulse_q     <= pulse_d;
        end
    end

    assign half_period  = half_q;
    assign period_valid = valid_q;
    assign period_ovf   = povf_q;
    assign prbs_lock    = lock_q;
    assign err_count    = err_q;
    assign err_pulse    = pulse_q;

endmodule

// File: tb/tb_prbs_div_checker.sv
// Bench for prbs_div_checker: per-cycle scoreboard against a behavioural model, plus directed spot checks.
module tb_prbs_div_checker;
    localparam int CNT_W       = 16;
    localparam int ERR_W       = 8;
    localparam int LOSS_THRESH = 4;
`ifdef ERR_CLEAR_EN
    localparam int ERR_FINAL = 0;
`else
    localparam int ERR_FINAL = 5;
`endif

    typedef struct packed {
        logic [CNT_W-1:0] half;
        logic             valid;
        logic             ovf;
        logic             lock;
        logic [ERR_W-1:0] err;
        logic             pulse;
    } obs_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ena = 1'b0;
    logic             div_in = 1'b0;
    logic             prbs_in = 1'b0;
    logic             err_clr = 1'b0;
    logic [CNT_W-1:0] half_period;
    logic             period_valid, period_ovf, prbs_lock, err_pulse;
    logic [ERR_W-1:0] err_count;

    prbs_div_checker #(.CNT_W(CNT_W), .ERR_W(ERR_W), .LOSS_THRESH(LOSS_THRESH)) dut (
        .clk(clk), .rst(rst), .ena(ena),
`ifdef ERR_CLEAR_EN
        .err_clr(err_clr),
`endif
        .div_in(div_in), .prbs_in(prbs_in),
        .half_period(half_period), .period_valid(period_valid), .period_ovf(period_ovf),
        .prbs_lock(prbs_lock), .err_count(err_count), .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc_no = 0;
    obs_t expq[$];

    // Behavioural model state
    int      m_half, m_err, seed_n, miss;
    bit      m_valid, m_ovf, m_lock, m_pulse, last_div, seen;
    longint  elapsed;
    bit      hist[$];

    // Stimulus state
    logic [15:0] gen;
    bit          cur_div;
    int          div_per, ph;
    bit          prbs_mode;

    function automatic obs_t dut_obs();
        obs_t o;
        o.half = half_period; o.valid = period_valid; o.ovf = period_ovf;
        o.lock = prbs_lock;   o.err = err_count;      o.pulse = err_pulse;
        return o;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.half = CNT_W'(m_half); o.valid = m_valid; o.ovf = m_ovf;
        o.lock = m_lock;         o.err = ERR_W'(m_err); o.pulse = m_pulse;
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic model(input bit r, input bit e, input bit d, input bit p, input bit c);
        bit any;
        bit pb;
        if (r) begin
            m_half = 0; m_valid = 0; m_ovf = 0; m_lock = 0; m_err = 0; m_pulse = 0;
            elapsed = 0; last_div = 0; seen = 0; seed_n = 0; miss = 0;
            hist.delete();
            repeat (16) hist.push_back(1'b0);
            return;
        end
        m_pulse = 0;
        if (e) begin
            // Interval length in enabled cycles between two div_in transitions, minus one.
            if (d != last_div) begin
                if (seen) begin
                    if (elapsed >= longint'((1 << CNT_W) - 1)) begin
                        m_ovf = 1; m_valid = 0;
                    end else begin
                        m_ovf = 0; m_valid = (elapsed == longint'(m_half)); m_half = int'(elapsed);
                    end
                end
                seen = 1; elapsed = 0;
            end else begin
                elapsed++;
            end
            last_div = d;
            if (!m_lock) begin
                hist.push_back(p); void'(hist.pop_front());
                seed_n++;
                if (seed_n == 16) begin
                    seed_n = 0;
                    any = 0;
                    foreach (hist[i]) any |= hist[i];
                    if (any) begin m_lock = 1; miss = 0; end
                end
            end else begin
                // Next bit of the recurrence x[n] = x[n-16]^x[n-14]^x[n-13]^x[n-11]
                pb = hist[0] ^ hist[2] ^ hist[3] ^ hist[5];
                hist.push_back(pb); void'(hist.pop_front());
                if (p != pb) begin
                    m_pulse = 1;
                    if (m_err < (1 << ERR_W) - 1) m_err++;
                    miss++;
                    if (miss == LOSS_THRESH) begin m_lock = 0; miss = 0; seed_n = 0; end
                end else begin
                    miss = 0;
                end
            end
        end
`ifdef ERR_CLEAR_EN
        if (c) m_err = 0;
`endif
    endtask

    task automatic step(input bit r, input bit e, input bit d, input bit p, input bit c);
        rst = r; ena = e; div_in = d; prbs_in = p; err_clr = c;
        model(r, e, d, p, c);
        expq.push_back(model_obs());
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input bit e, input bit flip, input bit c);
        bit b;
        if (e) begin
            if (div_per > 0) begin
                ph++;
                if (ph >= div_per) begin ph = 0; cur_div = ~cur_div; end
            end
            if (prbs_mode) begin
                b = gen[15] ^ gen[13] ^ gen[12] ^ gen[10];
                gen = {gen[14:0], b};
                b = b ^ flip;
            end else begin
                b = flip;
            end
        end else begin
            b = 1'($urandom);
        end
        step(1'b0, e, cur_div, b, c);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0);
    endtask

    task automatic set_div(input int per);
        div_per = per; ph = 0;
    endtask

    // Monitor: outputs are valid every cycle, compared against the queued model response.
    initial begin
        obs_t exp_o, got;
        forever begin
            @(posedge clk);
            #2;
            if (expq.size() > 0) begin
                exp_o = expq.pop_front();
                got   = dut_obs();
                cyc_no++;
                n_chk++;
                if (got !== exp_o) begin
                    n_err++;
                    $display("FAIL scoreboard cyc %0d: got half=%0d v=%0b ovf=%0b lock=%0b err=%0d pulse=%0b want half=%0d v=%0b ovf=%0b lock=%0b err=%0d pulse=%0b",
                             cyc_no, got.half, got.valid, got.ovf, got.lock, got.err, got.pulse,
                             exp_o.half, exp_o.valid, exp_o.ovf, exp_o.lock, exp_o.err, exp_o.pulse);
                end
            end
        end
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        gen = 16'h5555; cur_div = 0; prbs_mode = 1; set_div(5);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_state", 32'(dut_obs()), 32'd0);

        // Generator divide 4 and a clean PRBS stream, started together.
        for (int i = 0; i < 15; i++) cyc(1'b1, 1'b0, 1'b0);
        chk("lock_not_yet", 32'(prbs_lock), 32'd0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("lock_16", 32'(prbs_lock), 32'd1);
        chk("half_n4", 32'(half_period), 32'd4);
        chk("valid_n4", 32'(period_valid), 32'd1);
        chk("ovf_n4", 32'(period_ovf), 32'd0);
        run(1000);
        chk("clean_err", 32'(err_count), 32'd0);
        chk("clean_lock", 32'(prbs_lock), 32'd1);

        set_div(1); run(10);
        chk("half_n0", 32'(half_period), 32'd0);
        chk("valid_n0", 32'(period_valid), 32'd1);
        set_div(3); run(12);
        chk("half_n2", 32'(half_period), 32'd2);
        chk("valid_n2", 32'(period_valid), 32'd1);

        // One flipped bit, then a burst of LOSS_THRESH flips.
        cyc(1'b1, 1'b1, 1'b0);
        chk("single_pulse", 32'(err_pulse), 32'd1);
        run(20);
        chk("single_err", 32'(err_count), 32'd1);
        chk("single_lock", 32'(prbs_lock), 32'd1);
        repeat (4) cyc(1'b1, 1'b1, 1'b0);
        chk("loss_lock", 32'(prbs_lock), 32'd0);
        run(15);
        chk("relock_early", 32'(prbs_lock), 32'd0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("relock", 32'(prbs_lock), 32'd1);
        chk("relock_err", 32'(err_count), 32'd5);

`ifdef ERR_CLEAR_EN
        cyc(1'b1, 1'b0, 1'b1);
        chk("clr_err", 32'(err_count), 32'd0);
        cyc(1'b1, 1'b1, 1'b1);
        chk("clr_wins", 32'(err_count), 32'd0);
        run(5);
`endif

        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0);
        chk("hold_pulse", 32'(err_pulse), 32'd0);
        chk("hold_lock", 32'(prbs_lock), 32'd1);
        run(20);
        chk("resume_err", 32'(err_count), 32'(ERR_FINAL));

        // Randomised mix of divide changes, stalls and bit errors.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) set_div($urandom_range(1, 9));
            cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 63) == 0), 1'b0);
        end

        // Long hold: interval beyond the counter range.
        set_div(0); run(70000);
        set_div(5); ph = 4;
        cyc(1'b1, 1'b0, 1'b0);
        chk("ovf_set", 32'(period_ovf), 32'd1);
        chk("ovf_valid", 32'(period_valid), 32'd0);
        run(5);
        chk("ovf_clear", 32'(period_ovf), 32'd0);
        chk("ovf_half", 32'(half_period), 32'd4);

        chk("lock_before_rst", 32'(prbs_lock), 32'd1);
        step(1'b1, 1'b1, cur_div, 1'b1, 1'b0);
        chk("mid_reset", 32'(dut_obs()), 32'd0);

        prbs_mode = 0;
        run(100);
        chk("zeros_nolock", 32'(prbs_lock), 32'd0);

        repeat (3) @(posedge clk);
        #3;
        chk("queue_drained", 32'(expq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
